fphub_to_ieee_converter: RTL and testbench

//  Streaming 2-stage converter from FPHUB (implicit leading 1 and implicit trailing 1, ILSB) to

---
 rtl/fphub_pkg.sv | 25 ++
 rtl/fphub_round_unit.sv | 57 +++++
 rtl/fphub_to_ieee_converter.sv | 75 +++++++
 tb/tb_fphub_to_ieee_converter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fphub_pkg.sv
// FPHUB format definitions shared by the converter and the FPHUB adder.
// Word layout {s, e, F}: implicit leading 1 and implicit trailing 1 (ILSB) on the fraction.
package fphub_pkg;

  localparam int FPHUB_E = 8;
  localparam int FPHUB_M = 24;
  localparam int FPHUB_W = FPHUB_E + FPHUB_M + 1;

  localparam logic [FPHUB_E-1:0] EXP_ONES = '1;

  typedef struct packed {
    logic               s;
    logic [FPHUB_E-1:0] e;
    logic [FPHUB_M-1:0] f;
  } fphub_word_t;

  function automatic logic is_zero(input logic [FPHUB_E-1:0] e);
    return e == '0;
  endfunction

  function automatic logic is_inf(input logic [FPHUB_E-1:0] e);
    return e == EXP_ONES;
  endfunction

endpackage

// File: rtl/fphub_round_unit.sv
// Combinational FPHUB -> IEEE-style word conversion (decode specials, drop the ILSB).
// Build option FPHUB_CONV_RNE_EN: round-half-to-even instead of truncation.
module fphub_round_unit
  import fphub_pkg::*;
#(
  parameter int M = FPHUB_M,
  parameter int E = FPHUB_E
) (
  input  logic [E+M:0] word_i,
  output logic [E+M:0] word_o,
  output logic         ovf_o
);

  logic         s;
  logic [E-1:0] e;
  logic [M-1:0] f;

  assign s = word_i[E+M];
  assign e = word_i[E+M-1:M];
  assign f = word_i[M-1:0];

`ifdef FPHUB_CONV_RNE_EN
  // The dropped ILSB is exactly half an ulp, so every normal is a tie: odd fractions round up.
  function automatic logic [M:0] rne_incr(input logic [M-1:0] frac);
    return {1'b0, frac} + {{M{1'b0}}, frac[0]};
  endfunction

  logic [M:0]   sum;
  logic [E-1:0] e_inc;

  assign sum   = rne_incr(f);
  assign e_inc = e + {{(E-1){1'b0}}, 1'b1};
`endif

  always_comb begin
    word_o = word_i;
    ovf_o  = 1'b0;
    if (is_zero(e)) begin
      word_o = {s, {E{1'b0}}, {M{1'b0}}};
    end else if (is_inf(e)) begin
      word_o = {s, {E{1'b1}}, {M{1'b0}}};
    end
`ifdef FPHUB_CONV_RNE_EN
    else if (sum[M]) begin
      if (is_inf(e_inc)) begin
        word_o = {s, {E{1'b1}}, {M{1'b0}}};
        ovf_o  = 1'b1;
      end else begin
        word_o = {s, e_inc, {M{1'b0}}};
      end
    end else begin
      word_o = {s, e, sum[M-1:0]};
    end
`endif
  end

endmodule

// File: rtl/fphub_to_ieee_converter.sv
// Two-stage streaming FPHUB -> IEEE-style converter with valid/ready on both sides.
// Build option FPHUB_CONV_RNE_EN selects round-half-to-even (default: truncation).
module fphub_to_ieee_converter
  import fphub_pkg::*;
#(
  parameter int M = FPHUB_M,
  parameter int E = FPHUB_E
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [E+M:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [E+M:0] out_data,
  output logic         out_overflow
);

  logic         adv1, adv2;
  logic         vld_p1_q, vld_p1_d;
  logic         vld_p2_q, vld_p2_d;
  logic [E+M:0] data_p1_q, data_p2_q;
  logic         ovf_p1_q, ovf_p2_q;
  logic [E+M:0] rnd_word;
  logic         rnd_ovf;

  assign adv2     = !vld_p2_q || out_ready;
  assign adv1     = !vld_p1_q || adv2;
  assign in_ready = adv1 && !rst;

  fphub_round_unit #(.M(M), .E(E)) u_round (
    .word_i (in_data),
    .word_o (rnd_word),
    .ovf_o  (rnd_ovf)
  );

  always_comb begin
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    if (adv1) vld_p1_d = in_valid;
    if (adv2) vld_p2_d = vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // Stage 1: rounded word from the decode/round unit
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      data_p1_q <= rnd_word;
      ovf_p1_q  <= rnd_ovf;
    end
  end

  // Stage 2: output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (adv2 && vld_p1_q) begin
      data_p2_q <= data_p1_q;
      ovf_p2_q  <= ovf_p1_q;
    end
  end

  assign out_valid    = vld_p2_q && !rst;
  assign out_data     = out_valid ? data_p2_q : '0;
  assign out_overflow = out_valid && ovf_p2_q;

endmodule

// File: tb/tb_fphub_to_ieee_converter.sv
// Scoreboard bench for fphub_to_ieee_converter: directed cases, backpressure, reset, random traffic.
module tb_fphub_to_ieee_converter;

  localparam int E = 8;
  localparam int M = 24;
  localparam int W = E + M + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_overflow;

  always #5 clk = ~clk;

  fphub_to_ieee_converter #(.M(M), .E(E)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow)
  );

  int         checks = 0;
  int         failures = 0;
  int         fires = 0;
  int         stalls = 0;
  logic [W:0] exp_q[$];
  int         ready_mode = 0;
  logic       ready_force = 1'b1;

  logic [W-1:0] dir_in [5] = '{
    {1'b0, 8'h80, 24'h000001},
    {1'b1, 8'h7F, 24'hFFFFFF},
    {1'b0, 8'hFE, 24'hFFFFFF},
    {1'b1, 8'h00, 24'h123456},
    {1'b0, 8'hFF, 24'h000005}
  };
`ifdef FPHUB_CONV_RNE_EN
  logic [W:0] dir_exp [5] = '{
    {2'b00, 8'h80, 24'h000002},
    {2'b01, 8'h80, 24'h000000},
    {2'b10, 8'hFF, 24'h000000},
    {2'b01, 8'h00, 24'h000000},
    {2'b00, 8'hFF, 24'h000000}
  };
`else
  logic [W:0] dir_exp [5] = '{
    {2'b00, 8'h80, 24'h000001},
    {2'b01, 8'h7F, 24'hFFFFFF},
    {2'b00, 8'hFE, 24'hFFFFFF},
    {2'b01, 8'h00, 24'h000000},
    {2'b00, 8'hFF, 24'h000000}
  };
`endif

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Reference: value 1.F1 x 2^e, rounded to 1.F' by the chosen rule; returns {ovf, word}.
  function automatic logic [W:0] model(input logic [W-1:0] w);
    logic              s;
    int unsigned       e;
    longint unsigned   f, sig, keep;
    s = w[W-1];
    e = int'(w[W-2:M]);
    f = longint'(w[M-1:0]);
    if (e == 0)   return {1'b0, s, 32'h0};
    if (e == 255) return {1'b0, s, 8'hFF, 24'h0};
    sig  = ((((64'd1 << M) + f)) << 1) | 64'd1;
    keep = sig >> 1;
`ifdef FPHUB_CONV_RNE_EN
    if (keep[0]) keep = keep + 64'd1;
`endif
    if (keep == (64'd1 << (M + 1))) begin
      e    = e + 1;
      keep = 64'd1 << M;
    end
    if (e == 255) return {1'b1, s, 8'hFF, 24'h0};
    return {1'b0, s, e[7:0], keep[23:0]};
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [7:0]  e;
    logic [23:0] f;
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'hFE;
      3:       e = 8'h7F;
      default: e = 8'($urandom_range(1, 254));
    endcase
    f = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // Caller is at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [W-1:0] w, input logic [W:0] exp);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
      stalls++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp);
      @(negedge clk);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else                 out_ready = ready_force;
    end
  end

  initial begin
    logic         held_v;
    logic [W-1:0] held_d;
    logic [W:0]   e;
    held_v = 1'b0;
    held_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          if (out_valid) check("hold_data", 64'(out_data), 64'(held_d));
        end
        if (out_valid && out_ready) begin
          fires++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_word", 64'({out_overflow, out_data}), 64'(e));
          end
        end
        held_v = out_valid && !out_ready;
        held_d = out_data;
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    int           n0;
    int           t;
    logic         saw_low;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_overflow", 64'(out_overflow), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Latency: accept at edge P0, out_valid visible after P1
    send(dir_in[0], dir_exp[0]);
    in_valid = 1'b0;
    check("lat_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2", 64'(out_valid), 64'd1);
    for (int i = 1; i < 5; i++) send(dir_in[i], dir_exp[i]);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Backpressure: out_ready low for four cycles mid-burst
    n0 = fires;
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          w = {1'b0, 8'h80, 24'(i * 3 + 1)};
          send(w, model(w));
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 12; k++) begin
          if (k == 2) ready_force = 1'b0;
          if (k == 6) ready_force = 1'b1;
          @(negedge clk);
          if (!in_ready && in_valid) saw_low = 1'b1;
        end
      end
    join
    t = 0;
    while (fires - n0 < 8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_all_out", 64'(fires - n0), 64'd8);
    check("bp_in_ready_low", 64'(saw_low), 64'd1);
    repeat (3) @(negedge clk);

    // Throughput with out_ready steady high
    n0 = fires;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      w = {1'b1, 8'($urandom_range(1, 254)), 24'($urandom)};
      send(w, model(w));
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("tput_stalls", 64'(stalls), 64'd0);
    check("tput_count", 64'(fires - n0), 64'd8);

    // Reset with both stages full
    ready_force = 1'b0;
    repeat (2) @(negedge clk);
    send({1'b0, 8'h10, 24'h000111}, model({1'b0, 8'h10, 24'h000111}));
    send({1'b1, 8'h20, 24'h000222}, model({1'b1, 8'h20, 24'h000222}));
    in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ready_force = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    check("post_rst_still_idle", 64'(out_valid), 64'd0);
    repeat (3) @(negedge clk);

    // Random traffic with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      w = rand_word();
      send(w, model(w));
    end
    in_valid = 1'b0;
    ready_mode = 0;
    ready_force = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
